// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite constants and the command-master FSM state type.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_e;

endpackage

// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite bus bundle between the command master and a register slave.
interface axi_lite_cmd_master_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 4,
  parameter int unsigned AXI_DATA_WIDTH = 32
) ();

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

  logic [AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic [2:0]                M_AXI_AWPROT;
  logic                      M_AXI_AWVALID;
  logic                      M_AXI_AWREADY;
  logic [AXI_DATA_WIDTH-1:0] M_AXI_WDATA;
  logic [STRB_W-1:0]         M_AXI_WSTRB;
  logic                      M_AXI_WVALID;
  logic                      M_AXI_WREADY;
  logic [1:0]                M_AXI_BRESP;
  logic                      M_AXI_BVALID;
  logic                      M_AXI_BREADY;
  logic [AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic [2:0]                M_AXI_ARPROT;
  logic                      M_AXI_ARVALID;
  logic                      M_AXI_ARREADY;
  logic [AXI_DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [1:0]                M_AXI_RRESP;
  logic                      M_AXI_RVALID;
  logic                      M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );

endinterface

// File: rtl/axi_lite_cmd_master.sv
// Turns a one-command-at-a-time request stream into single AXI4-Lite
// transactions and returns one response beat per command.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 4
) (
  input  logic                        M_AXI_ACLK,
  input  logic                        M_AXI_ARESET,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_write,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  axi_lite_cmd_master_if.master       m_axi
);

  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

  state_e                    state_q, state_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      bready_q, bready_d;
  logic                      b_seen_q, b_seen_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_write_q, rsp_write_d;
  logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;

  assign cmd_ready = (state_q == IDLE) && !M_AXI_ARESET;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    b_seen_d    = b_seen_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d      = cmd_addr;
          rsp_write_d = cmd_write;
          if (cmd_write) begin
            wdata_d     = cmd_wdata;
            wstrb_d     = cmd_wstrb;
            awvalid_d   = 1'b1;
            wvalid_d    = 1'b1;
            bready_d    = 1'b1;
            b_seen_d    = 1'b0;
            rsp_rdata_d = '0;
            state_d     = WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end

      WR: begin
        // AW and W retire independently; B may land on the final handshake edge
        awvalid_d = awvalid_q && !m_axi.M_AXI_AWREADY;
        wvalid_d  = wvalid_q && !m_axi.M_AXI_WREADY;
        if (m_axi.M_AXI_BVALID && bready_q) begin
          b_seen_d   = 1'b1;
          bready_d   = 1'b0;
          rsp_resp_d = m_axi.M_AXI_BRESP;
        end
        if (!awvalid_d && !wvalid_d) begin
          if (b_seen_d) begin
            rsp_valid_d = 1'b1;
            state_d     = RSP;
          end else begin
            state_d = WR_RESP;
          end
        end
      end

      WR_RESP: begin
        if (m_axi.M_AXI_BVALID) begin
          bready_d    = 1'b0;
          rsp_resp_d  = m_axi.M_AXI_BRESP;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end

      RD_ADDR: begin
        if (m_axi.M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (m_axi.M_AXI_RVALID) begin
          rready_d    = 1'b0;
          rsp_rdata_d = m_axi.M_AXI_RDATA;
          rsp_resp_d  = m_axi.M_AXI_RRESP;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      b_seen_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      b_seen_q    <= b_seen_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign m_axi.M_AXI_AWADDR  = addr_q;
  assign m_axi.M_AXI_AWPROT  = PROT_DEFAULT;
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WDATA   = wdata_q;
  assign m_axi.M_AXI_WSTRB   = wstrb_q;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = bready_q;
  assign m_axi.M_AXI_ARADDR  = addr_q;
  assign m_axi.M_AXI_ARPROT  = PROT_DEFAULT;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = rready_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: a 4-register slave with programmable
// handshake delays and response codes, plus a register-array reference model.
module tb_axi_lite_cmd_master;
  import axi_lite_pkg::*;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_q = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    rst_q <= rst;
    cyc   <= cyc + 1;
  end

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  axi_lite_cmd_master_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) axi ();

  axi_lite_cmd_master #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
    .M_AXI_ACLK  (clk),
    .M_AXI_ARESET(rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_wstrb   (cmd_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_write   (rsp_write),
    .rsp_rdata   (rsp_rdata),
    .rsp_resp    (rsp_resp),
    .m_axi       (axi)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old_v;
    for (int i = 0; i < int'(SW); i++)
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  // Slave knobs and observations
  int         aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0] b_code = RESP_OKAY;
  logic [1:0] r_code = RESP_OKAY;
  int         aw_beats = 0, w_beats = 0, b_beats = 0, ar_beats = 0, r_beats = 0;
  int         aw_hs_cyc = 0, w_hs_cyc = 0;
  int         viol = 0;
  logic [DW-1:0] sregs [4];

  // Reference model of the register bank
  logic [DW-1:0] mregs [4];

  initial begin : slave_bfm
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic p_awv, p_wv, p_arv;
    logic [AW-1:0] p_awaddr, p_araddr, s_addr;
    logic [DW-1:0] p_wdata, s_wdata, s_rdata;
    logic [SW-1:0] p_wstrb, s_wstrb;
    logic aw_got, w_got, b_pend, r_pend;
    int aw_c, w_c, ar_c, b_c, r_c;
    aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
    aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
    s_addr = '0; s_wdata = '0; s_wstrb = '0; s_rdata = '0;
    for (int i = 0; i < 4; i++) sregs[i] = '0;
    axi.M_AXI_AWREADY = 1'b0; axi.M_AXI_WREADY = 1'b0; axi.M_AXI_ARREADY = 1'b0;
    axi.M_AXI_BVALID = 1'b0; axi.M_AXI_BRESP = 2'b00;
    axi.M_AXI_RVALID = 1'b0; axi.M_AXI_RRESP = 2'b00; axi.M_AXI_RDATA = '0;
    forever begin
      // Values held into the coming edge
      aw_hs = (axi.M_AXI_AWVALID === 1'b1) && axi.M_AXI_AWREADY;
      w_hs  = (axi.M_AXI_WVALID  === 1'b1) && axi.M_AXI_WREADY;
      ar_hs = (axi.M_AXI_ARVALID === 1'b1) && axi.M_AXI_ARREADY;
      b_hs  = axi.M_AXI_BVALID && (axi.M_AXI_BREADY === 1'b1);
      r_hs  = axi.M_AXI_RVALID && (axi.M_AXI_RREADY === 1'b1);
      p_awv = (axi.M_AXI_AWVALID === 1'b1); p_awaddr = axi.M_AXI_AWADDR;
      p_wv  = (axi.M_AXI_WVALID === 1'b1);  p_wdata = axi.M_AXI_WDATA; p_wstrb = axi.M_AXI_WSTRB;
      p_arv = (axi.M_AXI_ARVALID === 1'b1); p_araddr = axi.M_AXI_ARADDR;
      @(posedge clk);
      #2;
      if (rst_q) begin
        aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
        aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
        axi.M_AXI_AWREADY = 1'b0; axi.M_AXI_WREADY = 1'b0; axi.M_AXI_ARREADY = 1'b0;
        axi.M_AXI_BVALID = 1'b0; axi.M_AXI_RVALID = 1'b0;
      end else begin
        // A pending valid must hold with stable payload
        if (p_awv && !aw_hs && (axi.M_AXI_AWVALID !== 1'b1 || axi.M_AXI_AWADDR !== p_awaddr)) viol++;
        if (p_wv && !w_hs && (axi.M_AXI_WVALID !== 1'b1 || axi.M_AXI_WDATA !== p_wdata ||
                              axi.M_AXI_WSTRB !== p_wstrb)) viol++;
        if (p_arv && !ar_hs && (axi.M_AXI_ARVALID !== 1'b1 || axi.M_AXI_ARADDR !== p_araddr)) viol++;

        if (aw_hs) begin aw_got = 1'b1; s_addr = p_awaddr; aw_beats++; aw_hs_cyc = cyc; end
        if (w_hs)  begin w_got = 1'b1; s_wdata = p_wdata; s_wstrb = p_wstrb; w_beats++; w_hs_cyc = cyc; end
        if (b_hs)  begin b_pend = 1'b0; b_beats++; end
        if (ar_hs) begin r_pend = 1'b1; r_c = 0; ar_beats++; s_rdata = sregs[p_araddr[3:2]]; end
        if (r_hs)  begin r_pend = 1'b0; r_beats++; end
        if (aw_got && w_got && !b_pend) begin
          sregs[s_addr[3:2]] = merge(sregs[s_addr[3:2]], s_wdata, s_wstrb);
          aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1; b_c = 0;
        end

        if ((axi.M_AXI_AWVALID === 1'b1) && !aw_got) begin
          if (aw_c >= aw_dly) axi.M_AXI_AWREADY = 1'b1;
          else begin axi.M_AXI_AWREADY = 1'b0; aw_c++; end
        end else begin axi.M_AXI_AWREADY = 1'b0; aw_c = 0; end

        if ((axi.M_AXI_WVALID === 1'b1) && !w_got) begin
          if (w_c >= w_dly) axi.M_AXI_WREADY = 1'b1;
          else begin axi.M_AXI_WREADY = 1'b0; w_c++; end
        end else begin axi.M_AXI_WREADY = 1'b0; w_c = 0; end

        if ((axi.M_AXI_ARVALID === 1'b1) && !r_pend) begin
          if (ar_c >= ar_dly) axi.M_AXI_ARREADY = 1'b1;
          else begin axi.M_AXI_ARREADY = 1'b0; ar_c++; end
        end else begin axi.M_AXI_ARREADY = 1'b0; ar_c = 0; end

        axi.M_AXI_BRESP = b_code;
        if (b_pend && b_c >= b_dly) axi.M_AXI_BVALID = 1'b1;
        else begin axi.M_AXI_BVALID = 1'b0; if (b_pend) b_c++; end

        axi.M_AXI_RRESP = r_code;
        axi.M_AXI_RDATA = s_rdata;
        if (r_pend && r_c >= r_dly) axi.M_AXI_RVALID = 1'b1;
        else begin axi.M_AXI_RVALID = 1'b0; if (r_pend) r_c++; end
      end
    end
  end

  // One full command: accept, first-cycle bus check, response hold, beat counts
  task automatic do_cmd(input string tag, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [SW-1:0] s,
                        input int hold, input logic [1:0] exp_resp,
                        output logic [DW-1:0] obs_rdata);
    logic [DW-1:0] exp_rdata;
    logic acc;
    int n;
    int aw0, w0, b0, ar0, r0;
    aw0 = aw_beats; w0 = w_beats; b0 = b_beats; ar0 = ar_beats; r0 = r_beats;
    obs_rdata = '0;
    if (wr) begin
      exp_rdata = '0;
      mregs[a[3:2]] = merge(mregs[a[3:2]], d, s);
    end else begin
      exp_rdata = mregs[a[3:2]];
    end

    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0; acc = 1'b0;
    while (!acc && n < 50) begin
      acc = cmd_ready;
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    check({tag, "_accept"}, 64'(acc), 64'(1));
    if (!acc) return;

    if (wr) begin
      check({tag, "_awvalid"}, 64'(axi.M_AXI_AWVALID), 64'(1));
      check({tag, "_wvalid"},  64'(axi.M_AXI_WVALID),  64'(1));
      check({tag, "_awaddr"},  64'(axi.M_AXI_AWADDR),  64'(a));
      check({tag, "_wdata"},   64'(axi.M_AXI_WDATA),   64'(d));
      check({tag, "_wstrb"},   64'(axi.M_AXI_WSTRB),   64'(s));
      check({tag, "_bready"},  64'(axi.M_AXI_BREADY),  64'(1));
      check({tag, "_awprot"},  64'(axi.M_AXI_AWPROT),  64'(0));
    end else begin
      check({tag, "_arvalid"}, 64'(axi.M_AXI_ARVALID), 64'(1));
      check({tag, "_araddr"},  64'(axi.M_AXI_ARADDR),  64'(a));
      check({tag, "_arprot"},  64'(axi.M_AXI_ARPROT),  64'(0));
      check({tag, "_rready_early"}, 64'(axi.M_AXI_RREADY), 64'(0));
    end

    n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_rsp_arrives"}, 64'(rsp_valid === 1'b1), 64'(1));
    if (rsp_valid !== 1'b1) return;
    obs_rdata = rsp_rdata;

    for (int i = 0; i <= hold; i++) begin
      check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(1));
      check({tag, "_rsp_write"}, 64'(rsp_write), 64'(wr));
      check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
      check({tag, "_rsp_resp"},  64'(rsp_resp),  64'(exp_resp));
      check({tag, "_cmd_ready_busy"}, 64'(cmd_ready), 64'(0));
      if (i == hold) rsp_ready = 1'b1;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"},   64'(rsp_valid), 64'(0));
    check({tag, "_cmd_ready_back"}, 64'(cmd_ready), 64'(1));
    check({tag, "_aw_beats"}, 64'(aw_beats - aw0), 64'(wr ? 1 : 0));
    check({tag, "_w_beats"},  64'(w_beats - w0),   64'(wr ? 1 : 0));
    check({tag, "_b_beats"},  64'(b_beats - b0),   64'(wr ? 1 : 0));
    check({tag, "_ar_beats"}, 64'(ar_beats - ar0), 64'(wr ? 0 : 1));
    check({tag, "_r_beats"},  64'(r_beats - r0),   64'(wr ? 0 : 1));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [DW-1:0] rd;
    logic          wr;
    logic [AW-1:0] a;
    logic [1:0]    code;
    for (int i = 0; i < 4; i++) mregs[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_awvalid", 64'(axi.M_AXI_AWVALID), 64'(0));
    check("rst_wvalid",  64'(axi.M_AXI_WVALID),  64'(0));
    check("rst_arvalid", 64'(axi.M_AXI_ARVALID), 64'(0));
    check("rst_bready",  64'(axi.M_AXI_BREADY),  64'(0));
    check("rst_rready",  64'(axi.M_AXI_RREADY),  64'(0));
    check("rst_awaddr",  64'(axi.M_AXI_AWADDR),  64'(0));
    check("rst_wdata",   64'(axi.M_AXI_WDATA),   64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("rst_rsp_resp",  64'(rsp_resp),  64'(0));
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));

    // Basic write / read-back / unwritten register
    do_cmd("wr4", 1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 0, RESP_OKAY, rd);
    do_cmd("rd4", 1'b0, 4'h4, '0, '0, 0, RESP_OKAY, rd);
    check("rd4_literal", 64'(rd), 64'(32'hDEADBEEF));
    do_cmd("rd8", 1'b0, 4'h8, '0, '0, 0, RESP_OKAY, rd);
    check("rd8_literal", 64'(rd), 64'(0));

    // Partial strobe merge
    do_cmd("wrC_full", 1'b1, 4'hC, 32'hAABBCCDD, 4'hF, 0, RESP_OKAY, rd);
    do_cmd("wrC_part", 1'b1, 4'hC, 32'h11223344, 4'h3, 0, RESP_OKAY, rd);
    do_cmd("rdC", 1'b0, 4'hC, '0, '0, 0, RESP_OKAY, rd);
    check("rdC_literal", 64'(rd), 64'(32'hAABB3344));

    // Split AW/W handshakes in both orders
    aw_dly = 0; w_dly = 3;
    do_cmd("split_aw_first", 1'b1, 4'h0, 32'h0BADF00D, 4'hF, 0, RESP_OKAY, rd);
    check("split_aw_first_gap", 64'(w_hs_cyc - aw_hs_cyc), 64'(3));
    aw_dly = 3; w_dly = 0;
    do_cmd("split_w_first", 1'b1, 4'h8, 32'h12345678, 4'hF, 0, RESP_OKAY, rd);
    check("split_w_first_gap", 64'(aw_hs_cyc - w_hs_cyc), 64'(3));
    aw_dly = 0; w_dly = 0;

    // Error responses with response backpressure
    r_code = RESP_SLVERR;
    do_cmd("rd_slverr_bp", 1'b0, 4'h4, '0, '0, 5, RESP_SLVERR, rd);
    r_code = RESP_OKAY;
    b_code = RESP_DECERR; b_dly = 2;
    do_cmd("wr_decerr", 1'b1, 4'h4, 32'hCAFEF00D, 4'h5, 2, RESP_DECERR, rd);
    b_code = RESP_OKAY; b_dly = 0;

    // Randomised mix against the model
    for (int k = 0; k < 30; k++) begin
      wr = 1'($urandom_range(0, 1));
      a = {2'($urandom_range(0, 3)), 2'b00};
      aw_dly = int'($urandom_range(0, 3));
      w_dly  = int'($urandom_range(0, 3));
      ar_dly = int'($urandom_range(0, 3));
      b_dly  = int'($urandom_range(0, 3));
      r_dly  = int'($urandom_range(0, 3));
      code = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : RESP_OKAY;
      b_code = code; r_code = code;
      do_cmd($sformatf("rnd%0d", k), wr, a, DW'($urandom), SW'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)), code, rd);
    end
    aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0;
    b_code = RESP_OKAY; r_code = RESP_OKAY;

    // Reset in the middle of a write that the slave is stalling
    aw_dly = 8; w_dly = 8;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h0; cmd_wdata = 32'hFFFFFFFF; cmd_wstrb = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("midrst_awvalid_before", 64'(axi.M_AXI_AWVALID), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_awvalid", 64'(axi.M_AXI_AWVALID), 64'(0));
    check("midrst_wvalid",  64'(axi.M_AXI_WVALID),  64'(0));
    check("midrst_bready",  64'(axi.M_AXI_BREADY),  64'(0));
    check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("midrst_cmd_ready", 64'(cmd_ready), 64'(0));
    rst = 1'b0;
    #1;
    check("midrst_cmd_ready_after", 64'(cmd_ready), 64'(1));
    aw_dly = 0; w_dly = 0;
    @(posedge clk); #1;
    do_cmd("post_midrst_rd0", 1'b0, 4'h0, '0, '0, 0, RESP_OKAY, rd);

    check("no_valid_violations", 64'(viol), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
